// File: rtl/control_pkg.sv
// control_pkg: shared state, opcode, ALU-op and mux-select encodings for the multi-cycle control unit
package control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_TRAP     = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/control_aludec.sv
// control_aludec: maps R-type funct3/funct7b5 to an ALU operation and flags unsupported combinations
module control_aludec
    import control_pkg::*;
#(
    parameter int ALUOP_W = 4
) (
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               illegal
);

    // funct7b5 only distinguishes add from sub; the logic ops ignore it
    always_comb begin
        alu_op  = ALUOP_W'(ALU_ADD);
        illegal = 1'b0;
        case (funct3)
            3'b000:  alu_op = funct7b5 ? ALUOP_W'(ALU_SUB) : ALUOP_W'(ALU_ADD);
            3'b111:  alu_op = ALUOP_W'(ALU_AND);
            3'b110:  alu_op = ALUOP_W'(ALU_OR);
            3'b010:  alu_op = ALUOP_W'(ALU_SLT);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// control_multiciclo: multi-cycle RV32 control FSM with handshaked memory port and wait watchdog
// Optional retired-instruction counter enabled by defining CTRL_PERF_CNT_EN.
module control_multiciclo
    import control_pkg::*;
#(
    parameter int ALUOP_W     = 4,
    parameter int TIMEOUT_CYC = 16,
    parameter int PERF_W      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               adr_src,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         result_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               trap,
    output logic [3:0]         state_o
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]  retired
`endif
);

    localparam int CW     = $clog2(TIMEOUT_CYC > 2 ? TIMEOUT_CYC : 2);
    localparam int TO_MAX = TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_wait;
    logic               w_wait_st;
    logic               w_timeout;
    logic               w_illegal;
    logic [ALUOP_W-1:0] w_rop;

    control_aludec #(.ALUOP_W(ALUOP_W)) u_aludec (
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .alu_op   (w_rop),
        .illegal  (w_illegal)
    );

    assign w_wait_st = r_state inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
    // a ready arriving on the last allowed cycle still completes, so timeout requires !mem_ready
    assign w_timeout = (TIMEOUT_CYC != 0) && w_wait_st && !mem_ready && (r_wait == CW'(TO_MAX));
    assign state_o   = r_state;

    // state register and wait counter; the counter only runs while stalled in a request state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_wait_st && !mem_ready && w_next == r_state) ? r_wait + 1'b1 : '0;
        end
    end

    // next-state decode; unused encodings fall into TRAP
    always_comb begin
        w_next = S_TRAP;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : w_timeout ? S_TRAP : S_FETCH;
            S_DECODE:   w_next = (opcode == OP_LW || opcode == OP_SW)      ? S_MEMADR :
                                 (opcode == OP_R)                          ? S_EXECR  :
                                 (opcode == OP_I && funct3 == 3'b000)      ? S_EXECI  :
                                 (opcode == OP_BEQ && funct3 == 3'b000)    ? S_BEQ    : S_TRAP;
            S_MEMADR:   w_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = mem_ready ? S_MEMWB : w_timeout ? S_TRAP : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = mem_ready ? S_FETCH : w_timeout ? S_TRAP : S_MEMWRITE;
            S_EXECR:    w_next = w_illegal ? S_TRAP : S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            default:    w_next = S_TRAP;
        endcase
    end

    // Moore outputs per state, forced to idle while reset is asserted so no access escapes
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        alu_op     = ALUOP_W'(ALU_ADD);
        trap       = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMADR, S_EXECI: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    result_src = RES_MEM;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = w_rop;
                end
                S_ALUWB: reg_write = 1'b1;
                S_BEQ: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALUOP_W'(ALU_SUB);
                    pc_write  = zero;
                end
                S_TRAP:  trap = 1'b1;
                default: trap = 1'b1;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic w_retire;
    assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BEQ) ||
                      (r_state == S_MEMWRITE && mem_ready);

    // retirement counter; never advances in TRAP since no retiring state is reachable from it
    always_ff @(posedge clk) begin
        if (!rst_n) retired <= '0;
        else if (w_retire) retired <= retired + 1'b1;
    end
`endif

endmodule

// File: doc/control_multiciclo.md
Name: control_multiciclo

Overview:
Multi-cycle successor to the single-cycle RV32 control unit. It sequences each instruction through fetch, decode, execute, memory and writeback states over a shared ALU and a shared memory port. Memory accesses use a req/ready handshake with variable latency and a watchdog timeout. Supports lw, sw, beq, R-type add/sub/and/or/slt and I-type addi; anything else traps.

Parameters:
ALUOP_W, 4, ALU operation code width; encodings are AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111.
TIMEOUT_CYC, 16, maximum cycles waiting on mem_ready before trapping; 0 disables the timeout.
PERF_W, 32, width of the retired-instruction counter (optional feature).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
opcode  in  7  Instruction[6:0] from the external IR, stable from DECODE until the next FETCH
funct3  in  3  Instruction[14:12]
funct7b5  in  1  Instruction[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory handshake completion
mem_req  out  1  memory access request
mem_we  out  1  memory write enable, valid while mem_req=1
adr_src  out  1  0 = PC, 1 = ALUOut register
ir_write  out  1  IR and oldPC load strobe
pc_write  out  1  PC load strobe
reg_write  out  1  register file write
alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1
alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
result_src  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result
alu_op  out  ALUOP_W  ALU operation
trap  out  1  sticky illegal-instruction or timeout flag
state_o  out  4  current state encoding, for debug
retired  out  PERF_W  retired-instruction count (only with the macro)

Behaviour:
- Reset (rst_n=0 at a clk edge): state=FETCH, wait counter=0, trap=0. All strobes (mem_req, mem_we, ir_write, pc_write, reg_write) are 0 while in reset. All mux selects are 0 and alu_op=ADD.
- Outputs are a Moore decode of state. The exceptions are the ready-gated strobes, which are combinational in mem_ready and zero.
- FETCH: mem_req=1, adr_src=0, src_a=00, src_b=10, ADD, result_src=10. ir_write=pc_write=mem_ready. On mem_ready go to DECODE.
- DECODE: src_a=01, src_b=01, ADD (branch target into ALUOut). Next state:
  - lw/sw go to MEMADR.
  - 0110011 goes to EXECR.
  - 0010011 with funct3=000 goes to EXECI.
  - beq (1100011, funct3=000) goes to BEQ.
  - All else goes to TRAP.
- MEMADR: src_a=10, src_b=01, ADD. lw goes to MEMREAD; sw goes to MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. On mem_ready go to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, mem_we=1, adr_src=1. On mem_ready go to FETCH.
- EXECR: src_a=10, src_b=00. funct3/funct7b5 map to ops: 000/0 ADD, 000/1 SUB, 111 AND, 110 OR, 010 SLT. Any other combination goes to TRAP instead of ALUWB.
- EXECI: src_a=10, src_b=01, ADD, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BEQ: src_a=10, src_b=00, SUB, result_src=00, pc_write=zero, then FETCH (one cycle whether taken or not).
- TRAP: all strobes 0 and trap=1. The FSM stays in TRAP until reset.
- Wait counter: increments each cycle the FSM is in FETCH, MEMREAD or MEMWRITE with mem_ready=0, and clears on mem_ready or on any state change. If TIMEOUT_CYC≠0 and the counter reaches TIMEOUT_CYC-1 with mem_ready still 0, the next state is TRAP and the request drops.
- mem_ready arriving in the same cycle as the timeout: ready wins and the access completes normally. mem_ready outside a request state is ignored.
- Reset asserted mid-access: mem_req drops in the reset cycle and the in-flight access is abandoned.
- Retirement events: MEMWB, MEMWRITE with mem_ready, ALUWB, and BEQ.

Optional Feature:
CTRL_PERF_CNT_EN:
- Defined: `retired` counts retirement events, wraps modulo 2^PERF_W, clears on reset, and freezes in TRAP.
- Undefined: the `retired` port and the counter are absent.

Decomposition:
- Package control_pkg: state enum (4 bits), opcode localparams (lw, sw, beq, R-type, I-type), ALU op localparams, and the src_a/src_b/result_src encodings.
- Sub-module control_aludec: combinational funct3/funct7b5 to alu_op plus an illegal flag. EXECR consumes it.

Test Plan:
1. lw with mem_ready 3 cycles late in FETCH and 0 in MEMREAD: FETCH×4, DECODE, MEMADR, MEMREAD, MEMWB (reg_write=1, result_src=01), back to FETCH; retired=1.
2. R-type funct3=000, funct7b5=1: EXECR alu_op=0110, then ALUWB reg_write=1. With funct3=010: alu_op=0111.
3. beq with zero=1: pc_write=1 in BEQ. With zero=0: pc_write=0. Both return to FETCH after one cycle.
4. opcode 7'b1111111 in DECODE: TRAP, trap=1, no strobes for 20 cycles; rst_n=0 then returns to FETCH with trap=0.
5. TIMEOUT_CYC=16, mem_ready held 0 in MEMWRITE: TRAP on the 16th wait cycle. Repeat with mem_ready=1 on the 16th cycle: normal completion.
6. rst_n=0 for one cycle during MEMREAD: next cycle state=FETCH, mem_req=1, adr_src=0.
